// File: rtl/ssem_pkg.sv
// ----------------------------------------------------------------------------
// ssem_pkg
// Shared definitions for the store-side transfer logic: word and address
// geometry, instruction function codes, and the inward-transfer FSM state type.
// No ports (package).
// ----------------------------------------------------------------------------
package ssem_pkg;

    localparam int LINE_LENGTH         = 40;  // bits per store line / accumulator word
    localparam int ADDR_BITS           = 5;   // 32 store lines
    localparam int INSTR_FUNCTION_BITS = 6;   // width of the function staticisor
    localparam int BIT_CNT_BITS        = $clog2(LINE_LENGTH);

    // Function codes seen on the function staticisor
    localparam logic [INSTR_FUNCTION_BITS-1:0] INST_LDA = 6'b010000;
    localparam logic [INSTR_FUNCTION_BITS-1:0] INST_STA = 6'b010100;

    typedef enum logic [2:0] {
        ITU_IDLE   = 3'd0,
        ITU_ERASE  = 3'd1,
        ITU_WRITE  = 3'd2,
        ITU_VERIFY = 3'd3,
        ITU_DONE   = 3'd4
    } itu_state_t;

endpackage

// File: rtl/inward_transfer_unit_piso.sv
// ----------------------------------------------------------------------------
// itu_piso
// Parallel-load / serial-out register holding the word being stored, plus the
// bit counter that tracks the digit position within the line.
// The register rotates rather than shifts, so after LINE_LENGTH shifts it is
// back in its loaded order and can be replayed for a readback pass.
//
// Ports
//   clk      in   digit clock
//   rst_n    in   async active-low reset (clears register and counter)
//   load     in   capture data and zero the counter
//   data     in   [0:LINE_LENGTH-1] word, index 0 = least significant digit
//   shift    in   advance one digit (rotate, count up, saturate at LINE_LENGTH-1)
//   clear    in   zero the counter (a new pass begins next cycle)
//   bit_out  out  digit at the current position
//   last     out  counter is at LINE_LENGTH-1
// ----------------------------------------------------------------------------
module itu_piso
    import ssem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [0:LINE_LENGTH-1] data,
    input  logic                   shift,
    input  logic                   clear,
    output logic                   bit_out,
    output logic                   last
);

    localparam logic [BIT_CNT_BITS-1:0] LAST_IDX = BIT_CNT_BITS'(LINE_LENGTH - 1);

    logic [0:LINE_LENGTH-1]  shadow_q;
    logic [BIT_CNT_BITS-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            shadow_q <= data;
            cnt_q    <= '0;
        end else begin
            // Rotate so digit k+1 moves to position 0 and digit 0 wraps to the end
            if (shift) begin
                shadow_q <= {shadow_q[1:LINE_LENGTH-1], shadow_q[0]};
            end
            if (clear) begin
                cnt_q <= '0;
            end else if (shift && (cnt_q != LAST_IDX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bit_out = shadow_q[0];
    assign last    = (cnt_q == LAST_IDX);

endmodule

// File: rtl/inward_transfer_unit.sv
// ----------------------------------------------------------------------------
// inward_transfer_unit
// Store-direction transfer path: on an STA action beat it latches the
// accumulator word and the line address, erases the addressed store line and
// then writes the word bit-serially, least significant digit first.
//
// Optional feature macro: ITU_VERIFY_EN
//   defined   - a readback VERIFY pass of LINE_LENGTH cycles follows WRITE;
//               any mismatch sets the sticky w_VERIFY_ERR flag.
//   undefined - no VERIFY pass; w_MS_RE and w_VERIFY_ERR are held at 0.
//
// Ports
//   w_CLK          in   digit clock
//   w_RESET_N      in   async active-low reset
//   w_START        in   action-trigger pulse
//   w_PARA_ACTION  in   low during the action beat
//   b_FST          in   function staticisor
//   b_LST_out      in   line staticisor (store address)
//   b_A_DATA_OUT   in   accumulator word, index 0 = LSD
//   w_STOP         in   stop switch, aborts a transfer
//   w_MS_DATA_OUT  in   store serial read data (readback pass only)
//   b_MS_ADDR      out  latched line address
//   w_MS_ERASE     out  erase strobe for the addressed line
//   w_MS_WE        out  serial write enable
//   w_MS_DATA_IN   out  serial write data
//   w_MS_RE        out  serial read enable
//   w_BUSY         out  transfer in progress
//   w_DONE         out  one-cycle completion pulse
//   w_ABORTED      out  one-cycle pulse after a stop kills a transfer
//   w_VERIFY_ERR   out  sticky readback mismatch flag
// ----------------------------------------------------------------------------
module inward_transfer_unit
    import ssem_pkg::*;
(
    input  logic                           w_CLK,
    input  logic                           w_RESET_N,
    input  logic                           w_START,
    input  logic                           w_PARA_ACTION,
    input  logic [INSTR_FUNCTION_BITS-1:0] b_FST,
    input  logic [ADDR_BITS-1:0]           b_LST_out,
    input  logic [0:LINE_LENGTH-1]         b_A_DATA_OUT,
    input  logic                           w_STOP,
    input  logic                           w_MS_DATA_OUT,
    output logic [ADDR_BITS-1:0]           b_MS_ADDR,
    output logic                           w_MS_ERASE,
    output logic                           w_MS_WE,
    output logic                           w_MS_DATA_IN,
    output logic                           w_MS_RE,
    output logic                           w_BUSY,
    output logic                           w_DONE,
    output logic                           w_ABORTED,
    output logic                           w_VERIFY_ERR
);

    itu_state_t           state_q;
    itu_state_t           state_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 aborted_q;

    logic start_ok;
    logic accept;
    logic abort_now;
    logic shift;
    logic clear_cnt;
    logic bit_out;
    logic last_bit;

    // The stop switch vetoes a start arriving in the same cycle
    assign start_ok = w_START & ~w_PARA_ACTION & (b_FST == INST_STA) & ~w_STOP;

    itu_piso u_piso (
        .clk     (w_CLK),
        .rst_n   (w_RESET_N),
        .load    (accept),
        .data    (b_A_DATA_OUT),
        .shift   (shift),
        .clear   (clear_cnt),
        .bit_out (bit_out),
        .last    (last_bit)
    );

    always_ff @(posedge w_CLK or negedge w_RESET_N) begin
        if (!w_RESET_N) begin
            state_q   <= ITU_IDLE;
            addr_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aborted_q <= abort_now;
            if (accept) begin
                addr_q <= b_LST_out;
            end
        end
    end

    // Outputs are decoded from the registered state only, so an asynchronous
    // reset drops the store strobes immediately and they can never overlap.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        abort_now    = 1'b0;
        shift        = 1'b0;
        clear_cnt    = 1'b0;
        w_MS_ERASE   = 1'b0;
        w_MS_WE      = 1'b0;
        w_MS_DATA_IN = 1'b0;
        w_MS_RE      = 1'b0;
        w_BUSY       = 1'b1;
        w_DONE       = 1'b0;

        unique case (state_q)
            ITU_IDLE: begin
                w_BUSY = 1'b0;
                if (start_ok) begin
                    accept  = 1'b1;
                    state_d = ITU_ERASE;
                end
            end

            ITU_ERASE: begin
                w_MS_ERASE = 1'b1;
                if (w_STOP) begin
                    abort_now = 1'b1;
                    state_d   = ITU_IDLE;
                end else begin
                    state_d = ITU_WRITE;
                end
            end

            ITU_WRITE: begin
                w_MS_WE      = 1'b1;
                w_MS_DATA_IN = bit_out;
                shift        = 1'b1;
                if (w_STOP) begin
                    abort_now = 1'b1;
                    state_d   = ITU_IDLE;
                end else if (last_bit) begin
                    // Restart the digit count for a possible readback pass
                    clear_cnt = 1'b1;
`ifdef ITU_VERIFY_EN
                    state_d = ITU_VERIFY;
`else
                    state_d = ITU_DONE;
`endif
                end
            end

`ifdef ITU_VERIFY_EN
            ITU_VERIFY: begin
                w_MS_RE = 1'b1;
                shift   = 1'b1;
                if (w_STOP) begin
                    abort_now = 1'b1;
                    state_d   = ITU_IDLE;
                end else if (last_bit) begin
                    state_d = ITU_DONE;
                end
            end
`endif

            ITU_DONE: begin
                w_DONE  = 1'b1;
                state_d = ITU_IDLE;
            end

            default: begin
                state_d = ITU_IDLE;
            end
        endcase
    end

    assign b_MS_ADDR = addr_q;
    assign w_ABORTED = aborted_q;

`ifdef ITU_VERIFY_EN
    logic verify_err_q;

    // Sticky until the next accepted start; the shadow register replays the
    // written word so each read digit is compared to what was sent.
    always_ff @(posedge w_CLK or negedge w_RESET_N) begin
        if (!w_RESET_N) begin
            verify_err_q <= 1'b0;
        end else if (accept) begin
            verify_err_q <= 1'b0;
        end else if (w_MS_RE && (w_MS_DATA_OUT != bit_out)) begin
            verify_err_q <= 1'b1;
        end
    end

    assign w_VERIFY_ERR = verify_err_q;
`else
    // Readback data has no consumer without the verify pass
    logic unused_ok;
    assign unused_ok    = w_MS_DATA_OUT;
    assign w_VERIFY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_inward_transfer_unit.sv
`timescale 1ns/1ps
module tb_inward_transfer_unit;
    import ssem_pkg::*;

`ifdef ITU_VERIFY_EN
    localparam int DONE_CYC = 82;
`else
    localparam int DONE_CYC = 42;
`endif

    logic                           clk;
    logic                           rst_n;
    logic                           start;
    logic                           para_action;
    logic [INSTR_FUNCTION_BITS-1:0] fst;
    logic [ADDR_BITS-1:0]           lst;
    logic [0:LINE_LENGTH-1]         a_data;
    logic                           stop;
    logic                           ms_data_out;
    logic [ADDR_BITS-1:0]           ms_addr;
    logic                           ms_erase;
    logic                           ms_we;
    logic                           ms_data_in;
    logic                           ms_re;
    logic                           busy;
    logic                           done;
    logic                           aborted;
    logic                           verify_err;

    inward_transfer_unit dut (
        .w_CLK         (clk),
        .w_RESET_N     (rst_n),
        .w_START       (start),
        .w_PARA_ACTION (para_action),
        .b_FST         (fst),
        .b_LST_out     (lst),
        .b_A_DATA_OUT  (a_data),
        .w_STOP        (stop),
        .w_MS_DATA_OUT (ms_data_out),
        .b_MS_ADDR     (ms_addr),
        .w_MS_ERASE    (ms_erase),
        .w_MS_WE       (ms_we),
        .w_MS_DATA_IN  (ms_data_in),
        .w_MS_RE       (ms_re),
        .w_BUSY        (busy),
        .w_DONE        (done),
        .w_ABORTED     (aborted),
        .w_VERIFY_ERR  (verify_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- store model ----------------
    logic [LINE_LENGTH-1:0] mem [32] = '{default: '0};
    logic [5:0]             wr_ptr = '0;
    logic [5:0]             rd_ptr = '0;
    logic                   flip = 1'b0;

    always @(posedge clk) begin
        if (ms_erase) mem[ms_addr] <= '0;
        if (ms_we) begin
            mem[ms_addr][wr_ptr] <= ms_data_in;
            wr_ptr <= wr_ptr + 6'd1;
        end else begin
            wr_ptr <= '0;
        end
        if (ms_re) rd_ptr <= rd_ptr + 6'd1;
        else       rd_ptr <= '0;
    end

    assign ms_data_out = ms_re & (mem[ms_addr][rd_ptr] ^ (flip && (rd_ptr == 6'd7)));

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int c0    = 0;

    typedef struct {
        logic [ADDR_BITS-1:0]   addr;
        logic [LINE_LENGTH-1:0] word;
        logic                   abort;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [INSTR_FUNCTION_BITS-1:0] fst;
        logic                           para;
        logic                           stop;
        logic                           start;
        logic [ADDR_BITS-1:0]           addr;
        logic [LINE_LENGTH-1:0]         word;
        logic                           exp_accept;
    } vec_t;
    vec_t vt[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [0:LINE_LENGTH-1] to_port(input logic [LINE_LENGTH-1:0] v);
        logic [0:LINE_LENGTH-1] r;
        for (int k = 0; k < LINE_LENGTH; k++) r[k] = v[k];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives one cycle of trigger inputs (cycle 0) and returns at cycle 1
    task automatic drive_start(input logic [INSTR_FUNCTION_BITS-1:0] f, input logic p,
                               input logic s, input logic st,
                               input logic [ADDR_BITS-1:0] ad, input logic [LINE_LENGTH-1:0] w,
                               input logic exp_accept, input logic exp_abort);
        fst         = f;
        para_action = p;
        stop        = s;
        start       = st;
        lst         = ad;
        a_data      = to_port(w);
        c0          = cyc;
        if (exp_accept) sbq.push_back('{addr: ad, word: w, abort: exp_abort});
        step();
        start       = 1'b0;
        stop        = 1'b0;
        para_action = 1'b1;
    endtask

    task automatic wait_done(input int budget, output int at);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        at = done ? (cyc - c0) : -1;
    endtask

    // Scoreboard: every completion or abort must match the oldest accepted start
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if ($countones({ms_we, ms_erase, ms_re}) > 1) begin
                n_err++;
                $display("FAIL strobe_excl: we=%0b erase=%0b re=%0b", ms_we, ms_erase, ms_re);
            end
            if (done || aborted) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_end", {done, aborted}, 2'b00);
                end else begin
                    e = sbq.pop_front();
                    check("sb_kind", aborted, e.abort);
                    if (done) check("sb_line", mem[e.addr], e.word);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        logic [LINE_LENGTH-1:0] stream;
        logic                   we_all;
        logic                   seen;

        vt[0] = '{INST_STA, 1'b0, 1'b0, 1'b1, 5'd3,  40'h00000000A5, 1'b1};
        vt[1] = '{INST_LDA, 1'b0, 1'b0, 1'b1, 5'd4,  40'hFFFFFFFFFF, 1'b0};
        vt[2] = '{INST_STA, 1'b1, 1'b0, 1'b1, 5'd4,  40'hFFFFFFFFFF, 1'b0};
        vt[3] = '{INST_STA, 1'b0, 1'b1, 1'b1, 5'd4,  40'hFFFFFFFFFF, 1'b0};
        vt[4] = '{INST_STA, 1'b0, 1'b0, 1'b0, 5'd4,  40'hFFFFFFFFFF, 1'b0};
        vt[5] = '{INST_STA, 1'b0, 1'b0, 1'b1, 5'd31, 40'hFFFFFFFFFF, 1'b1};
        vt[6] = '{INST_STA, 1'b0, 1'b0, 1'b1, 5'd0,  40'h8000000001, 1'b1};
        vt[7] = '{INST_STA, 1'b0, 1'b0, 1'b1, 5'd17, 40'hC35A96F00D, 1'b1};

        rst_n       = 1'b0;
        start       = 1'b0;
        para_action = 1'b1;
        fst         = '0;
        lst         = '0;
        a_data      = '0;
        stop        = 1'b0;
        repeat (3) step();
        check("reset_outputs",
              {ms_addr, ms_erase, ms_we, ms_data_in, ms_re, busy, done, aborted, verify_err}, 64'd0);
        rst_n = 1'b1;
        step();

        // ---- test 1: detailed timing and bit order ----
        drive_start(INST_STA, 1'b0, 1'b0, 1'b1, 5'd3, 40'h00000000A5, 1'b1, 1'b0);
        check("t1_erase_c1", {ms_erase, ms_we, busy}, 3'b101);
        check("t1_addr", ms_addr, 5'd3);
        we_all = 1'b1;
        stream = '0;
        for (int k = 0; k < LINE_LENGTH; k++) begin
            step();
            stream[k] = ms_data_in;
            we_all    = we_all & ms_we;
        end
        check("t1_we_c2_41", we_all, 1'b1);
        check("t1_stream", stream, 40'h00000000A5);
        wait_done(200, at);
        check("t1_done_cycle", at, DONE_CYC);
        step();
        check("t1_idle_after", {busy, done}, 2'b00);

        // ---- table-driven vectors ----
        for (int i = 0; i < 8; i++) begin
            drive_start(vt[i].fst, vt[i].para, vt[i].stop, vt[i].start,
                        vt[i].addr, vt[i].word, vt[i].exp_accept, 1'b0);
            check($sformatf("v%0d_busy_c1", i), {busy, ms_erase}, {2{vt[i].exp_accept}});
            if (vt[i].exp_accept) begin
                wait_done(200, at);
                check($sformatf("v%0d_done_cycle", i), at, DONE_CYC);
                step();
            end else begin
                repeat (3) step();
                check($sformatf("v%0d_still_idle", i), {busy, ms_we, done}, 3'b000);
            end
        end

        // ---- test 3: second start while busy is ignored ----
        drive_start(INST_STA, 1'b0, 1'b0, 1'b1, 5'd5, 40'h123456789A, 1'b1, 1'b0);
        repeat (9) step();
        fst         = INST_STA;
        para_action = 1'b0;
        start       = 1'b1;
        lst         = 5'd9;
        a_data      = to_port(40'hFEDCBA9876);
        step();
        start       = 1'b0;
        para_action = 1'b1;
        check("t3_addr_held", ms_addr, 5'd5);
        wait_done(200, at);
        check("t3_done_cycle", at, DONE_CYC);
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | busy | ms_erase;
        end
        check("t3_not_queued", seen, 1'b0);
        check("t3_line9_untouched", mem[9], 40'h0);

        // ---- test 4: stop mid-write ----
        drive_start(INST_STA, 1'b0, 1'b0, 1'b1, 5'd11, 40'hFFFFFFFFFF, 1'b1, 1'b1);
        repeat (19) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t4_c21", {ms_we, aborted, busy, done}, 4'b0100);
        step();
        check("t4_abort_once", aborted, 1'b0);
        check("t4_partial_line", mem[11], 40'h000007FFFF);
        seen = 1'b0;
        repeat (5) begin
            step();
            seen = seen | done | aborted;
        end
        check("t4_no_done", seen, 1'b0);

        // ---- test 5: asynchronous reset mid-transfer ----
        drive_start(INST_STA, 1'b0, 1'b0, 1'b1, 5'd7, 40'hAAAAAAAAAA, 1'b1, 1'b0);
        repeat (14) step();
        check("t5_busy_c15", {busy, ms_we}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_clear",
              {ms_addr, ms_erase, ms_we, ms_data_in, ms_re, busy, done, aborted, verify_err}, 64'd0);
        sbq.delete();
        step();
        #2;
        rst_n = 1'b1;
        step();
        drive_start(INST_STA, 1'b0, 1'b0, 1'b1, 5'd7, 40'h0F0F0F0F0F, 1'b1, 1'b0);
        check("t5_restart_addr", ms_addr, 5'd7);
        wait_done(200, at);
        check("t5_done_cycle", at, DONE_CYC);
        step();

`ifdef ITU_VERIFY_EN
        // ---- test 6: readback mismatch sets the sticky flag ----
        flip = 1'b1;
        drive_start(INST_STA, 1'b0, 1'b0, 1'b1, 5'd12, 40'h5555555555, 1'b1, 1'b0);
        wait_done(200, at);
        check("t6_done_cycle", at, DONE_CYC);
        check("t6_verr_set", verify_err, 1'b1);
        step();
        check("t6_verr_sticky", verify_err, 1'b1);
        flip = 1'b0;
        drive_start(INST_STA, 1'b0, 1'b0, 1'b1, 5'd13, 40'h3333333333, 1'b1, 1'b0);
        check("t6_verr_cleared", verify_err, 1'b0);
        wait_done(200, at);
        check("t6_verr_clean", verify_err, 1'b0);
        step();
`endif

        repeat (2) step();
        check("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
